// File: rtl/hazard_pkg.sv
// Shared encodings and slot record for the decode-stage hazard scoreboard.
package hazard_pkg;

  localparam int unsigned REG_W = 3;

  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             ld;
  } slot_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-stage bundle between the decoder (master) and the hazard scoreboard (slave).
interface hazard_scoreboard_if #(
  parameter int unsigned REG_W = hazard_pkg::REG_W
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_rs_used;
  logic             id_rt_used;
  logic             id_regwrt;
  logic [REG_W-1:0] id_rd;
  logic             id_is_load;
  logic             flush;
  logic             stall;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
           id_regwrt, id_rd, id_is_load, flush,
    input  stall, fwd_a, fwd_b
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
           id_regwrt, id_rd, id_is_load, flush,
    output stall, fwd_a, fwd_b
  );
endinterface

// File: rtl/hazard_slot_cmp.sv
// Compares one shadow slot's destination against both decode sources.
module hazard_slot_cmp
  import hazard_pkg::*;
(
  input  slot_t            slot,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic             rs_used,
  input  logic             rt_used,
  output logic             m_rs,
  output logic             m_rt
);
  // r0 is an ordinary register here, so no zero-register exemption.
  assign m_rs = slot.v & rs_used & (slot.rd == rs);
  assign m_rt = slot.v & rt_used & (slot.rd == rt);
endmodule

// File: rtl/hazard_scoreboard.sv
// Decode interlock: shadows EX/MEM/WB writers, raises stall, counts stalls, watchdog.
// Define FORWARD_EN to enable load-use-only interlock with registered forwarding selects.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W     = hazard_pkg::REG_W,
  parameter int unsigned MAX_STALL = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_scoreboard_if.slave   bus,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic                 err
);
  localparam int unsigned RUN_W = $clog2(MAX_STALL + 1);

  slot_t ex_q, mem_q, wb_q;
  logic  ex_rs, ex_rt, mem_rs, mem_rt, wb_rs, wb_rt;
  logic  hazard;
  logic  stall;
  logic  [RUN_W-1:0] run_cnt;

  hazard_slot_cmp u_cmp_ex (
    .slot(ex_q), .rs(bus.id_rs), .rt(bus.id_rt),
    .rs_used(bus.id_rs_used), .rt_used(bus.id_rt_used),
    .m_rs(ex_rs), .m_rt(ex_rt)
  );

  hazard_slot_cmp u_cmp_mem (
    .slot(mem_q), .rs(bus.id_rs), .rt(bus.id_rt),
    .rs_used(bus.id_rs_used), .rt_used(bus.id_rt_used),
    .m_rs(mem_rs), .m_rt(mem_rt)
  );

  // WB matches never interlock: the register file bypasses its own write port.
  hazard_slot_cmp u_cmp_wb (
    .slot(wb_q), .rs(bus.id_rs), .rt(bus.id_rt),
    .rs_used(bus.id_rs_used), .rt_used(bus.id_rt_used),
    .m_rs(wb_rs), .m_rt(wb_rt)
  );

`ifdef FORWARD_EN
  assign hazard = (ex_rs | ex_rt) & ex_q.ld;
`else
  assign hazard = ex_rs | ex_rt | mem_rs | mem_rt;
`endif

  assign stall     = bus.id_valid & ~bus.flush & hazard;
  assign bus.stall = stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      wb_q     <= mem_q;
      mem_q    <= ex_q;
      ex_q.v   <= bus.id_valid & bus.id_regwrt & ~stall & ~bus.flush;
      ex_q.rd  <= bus.id_rd;
      ex_q.ld  <= bus.id_is_load;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      run_cnt   <= '0;
      err       <= 1'b0;
    end else begin
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (!stall)
        run_cnt <= '0;
      else if (run_cnt != RUN_W'(MAX_STALL))
        run_cnt <= run_cnt + 1'b1;
      // Set on the edge where the run reaches MAX_STALL.
      if (stall && (run_cnt == RUN_W'(MAX_STALL - 1)))
        err <= 1'b1;
    end
  end

`ifdef FORWARD_EN
  logic [1:0] fwd_a_q, fwd_b_q;

  function automatic logic [1:0] fwd_sel(input logic m_ex, input logic ex_ld,
                                         input logic m_mem);
    if (m_ex && !ex_ld) return FWD_EXMEM;
    else if (m_mem)     return FWD_MEMWB;
    else                return FWD_NONE;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || stall || bus.flush) begin
      fwd_a_q <= FWD_NONE;
      fwd_b_q <= FWD_NONE;
    end else begin
      fwd_a_q <= fwd_sel(ex_rs, ex_q.ld, mem_rs);
      fwd_b_q <= fwd_sel(ex_rt, ex_q.ld, mem_rt);
    end
  end

  assign bus.fwd_a = fwd_a_q;
  assign bus.fwd_b = fwd_b_q;
`else
  assign bus.fwd_a = FWD_NONE;
  assign bus.fwd_b = FWD_NONE;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; follows the FORWARD_EN build setting.
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] stall_cnt;
  logic err;
  int errors = 0;
  int checks = 0;

  hazard_scoreboard_if #(.REG_W(3)) bus ();

  hazard_scoreboard #(.REG_W(3), .MAX_STALL(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .stall_cnt(stall_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] rs, input logic rsu,
                       input logic [2:0] rt, input logic rtu, input logic wr,
                       input logic [2:0] rd, input logic ld);
    bus.id_valid = v;  bus.id_rs = rs; bus.id_rs_used = rsu;
    bus.id_rt = rt;    bus.id_rt_used = rtu;
    bus.id_regwrt = wr; bus.id_rd = rd; bus.id_is_load = ld;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    bus.flush = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0h exp=0", stall_cnt); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (bus.fwd_a !== 2'b00) begin errors++; $display("FAIL reset_fwd_a got=%b exp=00", bus.fwd_a); end
    checks++; if (bus.fwd_b !== 2'b00) begin errors++; $display("FAIL reset_fwd_b got=%b exp=00", bus.fwd_b); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", bus.stall); end
    // Empty slots hold rd=0; reading r0 must not match them.
    drive(1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 1'b1, 3'd5, 1'b0);
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_slots_empty got=%b exp=0", bus.stall); end
    idle();
  endtask

  task automatic test_raw_pair();
    do_reset();
    drive(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 1'b1, 3'd3, 1'b0);  // ADD r3
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL raw_add_stall got=%b exp=0", bus.stall); end
    tick();
    drive(1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 1'b1, 3'd4, 1'b0);  // SUB r4 <- r3,r1
`ifdef FORWARD_EN
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL raw_fwd_stall got=%b exp=0", bus.stall); end
    tick();
    checks++; if (bus.fwd_a !== 2'b01) begin errors++; $display("FAIL raw_fwd_a got=%b exp=01", bus.fwd_a); end
    checks++; if (bus.fwd_b !== 2'b00) begin errors++; $display("FAIL raw_fwd_b got=%b exp=00", bus.fwd_b); end
    idle();
    tick();
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL raw_cnt got=%0d exp=0", stall_cnt); end
`else
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL raw_stall1 got=%b exp=1", bus.stall); end
    tick();
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL raw_stall2 got=%b exp=1", bus.stall); end
    tick();
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL raw_stall3 got=%b exp=0", bus.stall); end
    tick();
    idle();
    checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL raw_cnt got=%0d exp=2", stall_cnt); end
    checks++; if (bus.fwd_a !== 2'b00) begin errors++; $display("FAIL raw_fwd_tied got=%b exp=00", bus.fwd_a); end
`endif
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 1'b1, 3'd2, 1'b1);  // LD r2
    tick();
    drive(1'b1, 3'd5, 1'b1, 3'd2, 1'b1, 1'b1, 3'd6, 1'b0);  // ADD r6 <- r5,r2
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL ld_stall1 got=%b exp=1", bus.stall); end
    tick();
`ifdef FORWARD_EN
    checks++; if (bus.fwd_b !== 2'b00) begin errors++; $display("FAIL ld_fwd_b_stall got=%b exp=00", bus.fwd_b); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL ld_stall2 got=%b exp=0", bus.stall); end
    tick();
    checks++; if (bus.fwd_b !== 2'b10) begin errors++; $display("FAIL ld_fwd_b got=%b exp=10", bus.fwd_b); end
    checks++; if (bus.fwd_a !== 2'b00) begin errors++; $display("FAIL ld_fwd_a got=%b exp=00", bus.fwd_a); end
    idle();
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL ld_cnt got=%0d exp=1", stall_cnt); end
`else
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL ld_stall2 got=%b exp=1", bus.stall); end
    tick();
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL ld_stall3 got=%b exp=0", bus.stall); end
    tick();
    idle();
    checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL ld_cnt got=%0d exp=2", stall_cnt); end
`endif
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, 3'd1, 1'b1, 3'd1, 1'b1, 1'b1, 3'd6, 1'b1);  // LD r6
    tick();
    bus.flush = 1'b1;
    drive(1'b1, 3'd6, 1'b1, 3'd0, 1'b0, 1'b1, 3'd7, 1'b0);  // killed: r7 <- r6
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL flush_stall got=%b exp=0", bus.stall); end
    tick();
    bus.flush = 1'b0;
    checks++; if (bus.fwd_a !== 2'b00) begin errors++; $display("FAIL flush_fwd_a got=%b exp=00", bus.fwd_a); end
    drive(1'b1, 3'd7, 1'b1, 3'd7, 1'b1, 1'b1, 3'd1, 1'b0);  // reads r7
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL flush_killed1 got=%b exp=0", bus.stall); end
    tick();
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL flush_killed2 got=%b exp=0", bus.stall); end
    checks++; if (bus.fwd_a !== 2'b00) begin errors++; $display("FAIL flush_fwd_a2 got=%b exp=00", bus.fwd_a); end
    idle();
    tick();
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL flush_cnt got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_watchdog();
    do_reset();
    force dut.hazard = 1'b1;
    drive(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 1'b0, 3'd0, 1'b0);
    repeat (3) tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wd_err3 got=%b exp=0", err); end
    checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL wd_cnt3 got=%0d exp=3", stall_cnt); end
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL wd_err4 got=%b exp=1", err); end
    checks++; if (stall_cnt !== 16'd4) begin errors++; $display("FAIL wd_cnt4 got=%0d exp=4", stall_cnt); end
    bus.id_valid = 1'b0;
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL wd_gap_stall got=%b exp=0", bus.stall); end
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL wd_sticky got=%b exp=1", err); end
    bus.id_valid = 1'b1;
    repeat (65540) tick();
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL wd_cnt_sat got=%0h exp=ffff", stall_cnt); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL wd_err_hold got=%b exp=1", err); end
    release dut.hazard;
    idle();
    tick();
  endtask

  task automatic test_rst_mid_stall();
    drive(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 1'b1, 3'd3, 1'b1);  // LD r3
    tick();
    drive(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 1'b1, 3'd4, 1'b0);
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL rstmid_pre got=%b exp=1", bus.stall); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall got=%b exp=0", bus.stall); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rstmid_err got=%b exp=0", err); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_cnt got=%0d exp=0", stall_cnt); end
    idle();
  endtask

  initial begin
    bus.flush = 1'b0;
    idle();
    test_reset();
    test_raw_pair();
    test_load_use();
    test_flush();
    test_watchdog();
    test_rst_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
